// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and sizes used by the iterative divider
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // shift {rem, quo} left, trial-subtract on WIDTH+1 bits; diff MSB set means the subtraction borrowed
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider; DIV_SIGNED_EN enables signed operands
module div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef DIV_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic neg_q;
    logic neg_r;

    // operand signs only matter for signed requests; magnitudes feed the unsigned core
    always_comb begin
        sign_a = is_signed & dividend[WIDTH-1];
        sign_b = is_signed & divisor[WIDTH-1];
        a_mag  = sign_a ? -dividend : dividend;
        b_mag  = sign_b ? -divisor : divisor;
    end

    // sign flags captured on accept, applied in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = is_signed;

    // unsigned-only build: operands pass straight to the core
    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // FSM, iteration counter and result registers; results only move on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        cnt   <= CW'(WIDTH);
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    cnt   <= cnt - CW'(1);
                    state <= (cnt == CW'(1)) ? FIX : CALC;
                end
                FIX: begin
`ifdef DIV_SIGNED_EN
                    quotient  <= neg_q ? -quo : quo;
                    remainder <= neg_r ? -rem : rem;
`else
                    quotient  <= quo;
                    remainder <= rem;
`endif
                    div_by_zero <= 1'b0;
                    state       <= DONE;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: {div_by_zero, quotient, remainder} from plain arithmetic
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic        sg;
        logic [31:0] q;
        logic [31:0] r;
`ifdef DIV_SIGNED_EN
        sg = s;
`else
        sg = s & 1'b0;
`endif
        if (b == 0) return {1'b1, 32'hFFFF_FFFF, a};
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'h0};
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        logic [64:0] e;
        int lat;
        e = model(a, b, s);
        accept(a, b, s);
        wait_valid(lat);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_q"}, 64'(quotient), 64'(e[63:32]));
        chk({tag, "_r"}, 64'(remainder), 64'(e[31:0]));
        chk({tag, "_z"}, 64'(div_by_zero), 64'(e[64]));
        chk({tag, "_lat"}, 64'(lat), e[64] ? 64'd1 : 64'd34);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_z", 64'(div_by_zero), 64'd0);

        check_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
        chk("u100_7_q_const", 64'(quotient), 64'd14);
        check_op("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 1);
`ifdef DIV_SIGNED_EN
        chk("s_m7_2_q_const", 64'(quotient), 64'hFFFF_FFFD);
        chk("s_m7_2_r_const", 64'(remainder), 64'hFFFF_FFFF);
`else
        chk("s_m7_2_q_const", 64'(quotient), 64'h7FFF_FFFC);
        chk("s_m7_2_r_const", 64'(remainder), 64'h1);
`endif
        check_op("dbz", 32'h1234, 32'h0, 1'b0, 0);
        check_op("dbz_s", 32'h8000_0001, 32'h0, 1'b1, 0);
        check_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        check_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        check_op("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 0);
        check_op("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 0);
        check_op("u_small_big", 32'd5, 32'hFFFF_0000, 1'b0, 0);

        accept(32'd1000, 32'd10, 1'b0);
        wait_valid(lat);
        chk("bp_lat", 64'(lat), 64'd34);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_q", 64'(quotient), 64'd100);
            chk("bp_r", 64'(remainder), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = (i == 2);
            dividend = 32'd77;
            divisor  = 32'd0;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("bp_q_after", 64'(quotient), 64'd100);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_ready_next", 64'(in_ready), 64'd1);
        chk("bp_no_extra", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1 chk("bp_still_idle", 64'(out_valid), 64'd0);

        accept(32'd50, 32'd5, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_q", 64'(quotient), 64'd0);
        chk("abort_r", 64'(remainder), 64'd0);
        repeat (40) @(posedge clk);
        #1 chk("abort_no_result", 64'(out_valid), 64'd0);
        check_op("after_abort", 32'd9, 32'd3, 1'b0, 0);

        accept(32'd9, 32'd0, 1'b0);
        #0 chk("done_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("done_rst_out_valid", 64'(out_valid), 64'd0);
        chk("done_rst_z", 64'(div_by_zero), 64'd0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(0, 15));
                1: b = 32'h0;
                2: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            check_op($sformatf("rnd%0d", i), a, b, 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
